// File: rtl/mfcc_feature_buffer.sv
// -----------------------------------------------------------------------------
// mfcc_feature_buffer
//
// Collects MFCC frames into a ring of NUM_FRAMES+1 frame slots and, on request,
// streams the most recent NUM_FRAMES frames out as a ready/valid word stream.
// Streaming order is oldest frame first, and coefficient 0 first within a frame.
// The extra (spare) slot lets one new frame land while a window is being read,
// without corrupting the frames that are being streamed.
//
// Ports
//   clk              : clock, rising edge
//   rst              : asynchronous active-high reset
//   mfcc_done_i      : one-cycle pulse, new frame valid on mfcc_data_i
//   mfcc_data_i      : NUM_COEFFICIENTS x COEF_WIDTH packed array, c0 in the LSBs
//   window_start_i   : pulse requesting readout of the latest NUM_FRAMES frames
//   rd_valid_o       : rd_data_o holds a valid word
//   rd_ready_i       : consumer accepts the current word
//   rd_data_o        : streamed coefficient
//   rd_last_o        : final word of the window
//   frames_avail_o   : stored complete frames, saturating at NUM_FRAMES
//   busy_o           : readout in progress
//   overflow_o       : sticky, at least one frame was dropped
//   ovf_count_o      : dropped-frame count (see macro below)
//
// Configuration macro
//   MFCC_FEATBUF_OVF_CNT_EN : when defined, ovf_count_o is a saturating count of
//                             dropped frames; otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module mfcc_feature_buffer #(
  parameter int NUM_COEFFICIENTS = 13,
  parameter int COEF_WIDTH       = 16,
  parameter int NUM_FRAMES       = 49
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     mfcc_done_i,
  input  logic [NUM_COEFFICIENTS*COEF_WIDTH-1:0]   mfcc_data_i,
  input  logic                                     window_start_i,
  output logic                                     rd_valid_o,
  input  logic                                     rd_ready_i,
  output logic [COEF_WIDTH-1:0]                    rd_data_o,
  output logic                                     rd_last_o,
  output logic [$clog2(NUM_FRAMES+1)-1:0]          frames_avail_o,
  output logic                                     busy_o,
  output logic                                     overflow_o,
  output logic [15:0]                              ovf_count_o
);

  localparam int NC     = NUM_COEFFICIENTS;
  localparam int SLOTS  = NUM_FRAMES + 1;
  localparam int SLOT_W = $clog2(SLOTS);
  localparam int IDX_W  = (NC > 1) ? $clog2(NC) : 1;
  localparam int AV_W   = $clog2(NUM_FRAMES + 1);
  localparam int WORDS  = NUM_FRAMES * NC;
  localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_FRAMES);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NC - 1);
  localparam logic [AV_W-1:0]   FULL      = AV_W'(NUM_FRAMES);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Write side
  logic                  wr_busy_q;
  logic [IDX_W-1:0]      wr_idx_q;
  logic [SLOT_W-1:0]     wr_slot_q;
  logic [AV_W-1:0]       frames_avail_q;
  logic                  overflow_q;
  logic                  wr_accept;
  logic                  wr_drop;

  // Read side
  logic [SLOT_W-1:0]     spare_slot_q;
  logic [SLOT_W-1:0]     rd_slot_q;
  logic [IDX_W-1:0]      rd_coef_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic                  rd_valid_q;
  logic                  rd_last_q;
  logic                  snap;
  logic                  load;
  logic                  finish;

  // Storage (not reset)
  logic [COEF_WIDTH-1:0] frame_q [NC];
  logic [COEF_WIDTH-1:0] mem_q   [SLOTS][NC];
  logic [COEF_WIDTH-1:0] rd_data_q;

  function automatic logic [SLOT_W-1:0] next_slot(input logic [SLOT_W-1:0] s);
    return (s == LAST_SLOT) ? '0 : s + SLOT_W'(1);
  endfunction

  // While a window is being read, only the spare slot may be overwritten; once
  // the spare has been filled wr_slot points into the window and further frames
  // are dropped until the readout completes.
  assign wr_accept = mfcc_done_i && !wr_busy_q &&
                     ((state_q == S_IDLE) || (wr_slot_q == spare_slot_q));
  assign wr_drop   = mfcc_done_i && !wr_accept;

  always_comb begin
    state_d = state_q;
    snap    = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (window_start_i && (frames_avail_q == FULL)) begin
          state_d = S_ISSUE;
          snap    = 1'b1;
        end
      end
      S_ISSUE: begin
        load    = 1'b1;
        state_d = S_STREAM;
      end
      S_STREAM: begin
        if (rd_ready_i) begin
          if (rd_last_q) begin
            finish  = 1'b1;
            state_d = S_IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      wr_busy_q      <= 1'b0;
      wr_idx_q       <= '0;
      wr_slot_q      <= '0;
      frames_avail_q <= '0;
      overflow_q     <= 1'b0;
      spare_slot_q   <= '0;
      rd_slot_q      <= '0;
      rd_coef_q      <= '0;
      rd_cnt_q       <= '0;
      rd_valid_q     <= 1'b0;
      rd_last_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      // Write sequencer: one word per cycle after the frame is latched; the
      // frame only counts once its last word is in.
      if (wr_accept) begin
        wr_busy_q <= 1'b1;
        wr_idx_q  <= '0;
      end else if (wr_busy_q) begin
        if (wr_idx_q == LAST_IDX) begin
          wr_busy_q <= 1'b0;
          wr_slot_q <= next_slot(wr_slot_q);
          if (frames_avail_q != FULL) begin
            frames_avail_q <= frames_avail_q + AV_W'(1);
          end
        end else begin
          wr_idx_q <= wr_idx_q + IDX_W'(1);
        end
      end

      if (wr_drop) begin
        overflow_q <= 1'b1;
      end

      // The slot after wr_slot is the oldest complete frame in a full ring.
      if (snap) begin
        spare_slot_q <= wr_slot_q;
        rd_slot_q    <= next_slot(wr_slot_q);
        rd_coef_q    <= '0;
        rd_cnt_q     <= '0;
      end

      if (load) begin
        rd_valid_q <= 1'b1;
        rd_last_q  <= (rd_cnt_q == LAST_WORD);
        rd_cnt_q   <= rd_cnt_q + CNT_W'(1);
        if (rd_coef_q == LAST_IDX) begin
          rd_coef_q <= '0;
          rd_slot_q <= next_slot(rd_slot_q);
        end else begin
          rd_coef_q <= rd_coef_q + IDX_W'(1);
        end
      end

      if (finish) begin
        rd_valid_q <= 1'b0;
        rd_last_q  <= 1'b0;
      end
    end
  end

  // Datapath registers carry no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int k = 0; k < NC; k++) begin
        frame_q[k] <= mfcc_data_i[k*COEF_WIDTH +: COEF_WIDTH];
      end
    end
    if (wr_busy_q) begin
      mem_q[wr_slot_q][wr_idx_q] <= frame_q[wr_idx_q];
    end
    if (load) begin
      rd_data_q <= mem_q[rd_slot_q][rd_coef_q];
    end
  end

`ifdef MFCC_FEATBUF_OVF_CNT_EN
  logic [15:0] ovf_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
    end else if (wr_drop && (ovf_cnt_q != 16'hFFFF)) begin
      ovf_cnt_q <= ovf_cnt_q + 16'd1;
    end
  end

  assign ovf_count_o = ovf_cnt_q;
`else
  assign ovf_count_o = 16'd0;
`endif

  assign rd_valid_o     = rd_valid_q;
  assign rd_data_o      = rd_data_q;
  assign rd_last_o      = rd_last_q;
  assign frames_avail_o = frames_avail_q;
  assign busy_o         = (state_q != S_IDLE);
  assign overflow_o     = overflow_q;

endmodule
